// File: rtl/iir_pkg.sv
// Shared constants for the eighth-order IIR filter pair (forward filter and its
// inverse): coefficients, word sizes and the inverse-MAC state encoding.
package iir_pkg;

   localparam int ORDER         = 8;
   localparam int WORD_SIZE_IN  = 8;
   localparam int WORD_SIZE_OUT = 18;

   localparam logic [WORD_SIZE_IN-1:0] A1 = 8'd46;
   localparam logic [WORD_SIZE_IN-1:0] A2 = 8'd32;
   localparam logic [WORD_SIZE_IN-1:0] A3 = 8'd17;
   localparam logic [WORD_SIZE_IN-1:0] A4 = 8'd0;
   localparam logic [WORD_SIZE_IN-1:0] A5 = 8'd17;
   localparam logic [WORD_SIZE_IN-1:0] A6 = 8'd32;
   localparam logic [WORD_SIZE_IN-1:0] A7 = 8'd46;
   localparam logic [WORD_SIZE_IN-1:0] A8 = 8'd52;

   localparam logic [WORD_SIZE_IN-1:0] B0 = 8'd7;
   localparam logic [WORD_SIZE_IN-1:0] B1 = 8'd0;
   localparam logic [WORD_SIZE_IN-1:0] B2 = 8'd0;
   localparam logic [WORD_SIZE_IN-1:0] B3 = 8'd0;
   localparam logic [WORD_SIZE_IN-1:0] B4 = 8'd0;
   localparam logic [WORD_SIZE_IN-1:0] B5 = 8'd0;
   localparam logic [WORD_SIZE_IN-1:0] B6 = 8'd0;
   localparam logic [WORD_SIZE_IN-1:0] B7 = 8'd0;
   localparam logic [WORD_SIZE_IN-1:0] B8 = 8'd0;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

endpackage

// File: rtl/iir_inverse_mac_sample_history.sv
// Eight-deep history of past output low bytes; index 1 is the most recent.
// Tap-select read port returns hist[i_sel], zero for out-of-range selects.
module sample_history
   import iir_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    i_shift,
   input  logic [WORD_SIZE_IN-1:0] i_din,
   input  logic [3:0]              i_sel,
   output logic [WORD_SIZE_IN-1:0] o_tap
);

   logic [ORDER:1][WORD_SIZE_IN-1:0] r_hist;

   always_ff @(posedge clock) begin
      if (reset)
         r_hist <= '0;
      else if (i_shift)
         r_hist <= {r_hist[ORDER-1:1], i_din};
   end

   always_comb begin
      o_tap = '0;
      for (int i = 1; i <= ORDER; i++)
         if (i_sel == 4'(i)) o_tap = r_hist[i];
   end

endmodule

// File: rtl/iir_inverse_mac.sv
// Whitening filter for the IIR feedback path: subtracts sum a_k*hist[k] from each
// incoming y using one multiplier over eight cycles, then presents the result.
module iir_inverse_mac
   import iir_pkg::*;
#(
   parameter logic [ORDER:1][WORD_SIZE_IN-1:0] A_COEF = {A8, A7, A6, A5, A4, A3, A2, A1}
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WORD_SIZE_OUT-1:0] Data_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WORD_SIZE_OUT-1:0] Data_out
);

   state_t                   r_state;
   logic [WORD_SIZE_OUT-1:0] r_acc;
   logic [WORD_SIZE_IN-1:0]  r_y_hold;
   logic [3:0]               r_k;
   logic                     r_in_ready;
   logic                     r_out_valid;

   logic [WORD_SIZE_IN-1:0]    w_tap;
   logic [WORD_SIZE_IN-1:0]    w_coef;
   logic [2*WORD_SIZE_IN-1:0]  w_prod;
   logic                       w_shift;

   // History advances only on the output handshake, never while stalled.
   assign w_shift = r_out_valid & out_ready;

   sample_history u_hist (
      .clock  (clock),
      .reset  (reset),
      .i_shift(w_shift),
      .i_din  (r_y_hold),
      .i_sel  (r_k),
      .o_tap  (w_tap)
   );

   always_comb begin
      w_coef = '0;
      for (int i = 1; i <= ORDER; i++)
         if (r_k == 4'(i)) w_coef = A_COEF[i];
   end

   assign w_prod = w_coef * w_tap;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_y_hold    <= '0;
         r_k         <= 4'd1;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_acc      <= Data_in;
               r_y_hold   <= Data_in[WORD_SIZE_IN-1:0];
               r_k        <= 4'd1;
               r_in_ready <= 1'b0;
               r_state    <= MAC;
            end
            MAC: begin
               r_acc <= r_acc - {{(WORD_SIZE_OUT-2*WORD_SIZE_IN){1'b0}}, w_prod};
               if (r_k == 4'(ORDER)) begin
                  r_k         <= 4'd1;
                  r_out_valid <= 1'b1;
                  r_state     <= OUT;
               end else begin
                  r_k <= r_k + 4'd1;
               end
            end
            OUT: if (out_ready) begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign Data_out  = r_acc;

endmodule

// File: doc/iir_inverse_mac.md
# iir_inverse_mac

Inverse (whitening) filter for the eighth-order IIR filter's feedback path. It accepts one 18-bit filter output sample per handshake and removes the feedback contribution: Data_out[n] = y[n] − Σ a_k·(y[n−k] mod 256), k = 1..8, modulo 2^18. History holds only the low 8 bits of each past output, which matches how the forward filter stores its feedback samples, so the inversion is exact. It sits at the receive end of the filter's output, recovers b-weighted input (7·x[n] for the default b0 = 7, b1..b8 = 0), and uses a single time-multiplexed multiplier.

## Interface
- order, 8, number of feedback taps (fixed at 8 in this revision)
- word_size_in, 8, stored history width (low bits of past y)
- word_size_out, 18, sample width of y and Data_out
- a1..a8, 46, 32, 17, 0, 17, 32, 46, 52, unsigned 8-bit feedback coefficients; must equal the forward filter's values
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clock clock
- in_valid  input  1  Data_in valid
- in_ready  output  1  block can accept a sample
- Data_in  input  18  filter output sample y[n], unsigned
- out_valid  output  1  Data_out valid
- out_ready  input  1  downstream accepts Data_out
- Data_out  output  18  recovered sample, unsigned modulo 2^18

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid: acc←Data_in, y_hold←Data_in, k←1, go to MAC.
  - MAC: in_ready=0. Each cycle: acc←acc − a_k·hist[k] (18-bit wrap), k←k+1. After the k=8 update, go to OUT.
  - OUT: out_valid=1, Data_out=acc held stable. On out_ready: hist[k]←hist[k−1] for k=2..8, hist[1]←y_hold[7:0], go to IDLE.
- Arithmetic:
  - Products are 16 bits (8×8), zero-extended to 18 bits.
  - Subtraction wraps modulo 2^18; no saturation.
- History updates only on the output handshake. A sample stalled in OUT does not advance history.
- No acceptance in OUT or MAC (no overlap); throughput is at most one sample per 10 cycles.
- Reset, including mid-MAC or mid-OUT:
  - Pending sample is discarded.
  - hist[1..8]=0, acc=0, y_hold=0, k=1, state IDLE.
- Reset-state outputs: in_ready=1, out_valid=0, Data_out=0.

## Timing
- Acceptance edge E0 (IDLE, in_valid=1). MAC updates occur on edges E1..E8. out_valid is high after E8, a latency of 8 cycles from the cycle following acceptance.
- in_ready falls immediately after E0 and stays low until the output handshake edge.
- in_ready returns high in the cycle after the output handshake. Earliest next acceptance is the following edge, giving a minimum period of 10 cycles.
- Data_out and out_valid are registered; they do not change while out_valid=1 and out_ready=0.
- in_valid while in_ready=0 is ignored; upstream must hold the sample.

## Structure
- Shared package iir_pkg:
  - default coefficient constants A1..A8 and B0..B8 (shared with the forward filter)
  - word-size constants
  - FSM state enum {IDLE, MAC, OUT}
- Sub-module sample_history: 8-deep × 8-bit shift register with a shift enable and a tap-select read port (k→hist[k]); reset clears to zero.
- Top level holds the FSM, accumulator, tap counter, and single multiplier.

## Test plan
- Reset: assert reset for 2 cycles. Required: in_ready=1, out_valid=0, Data_out=0; all history reads 0.
- Impulse from forward filter (b0=7, x=1,0,0,…, giving y=7, 322, …). Required:
  - first output 7, appearing 8 cycles after acceptance;
  - second output 322 − 46·7 = 0;
  - subsequent outputs 0 for 10 samples;
  - a random 8-bit x stream through the forward model yields 7·x on every output.
- Wrap: after history y=1, feed y=0. Required: Data_out = 2^18 − 46 = 262098.
- Backpressure: hold out_ready=0 for 5 cycles in OUT. Required:
  - Data_out and out_valid stable;
  - in_ready=0;
  - history unchanged until the handshake edge.
- Reset mid-MAC: assert reset at E4 of a sample. Required:
  - next cycle IDLE, out_valid=0;
  - that sample is never output;
  - next input y=5 produces 5.
- Back-to-back in_valid held high. Required: acceptances exactly 10 cycles apart with out_ready=1; no sample dropped or duplicated.
